ahblite_busmatrix_outputstage_dtcm: RTL and testbench
=====================================================

Name: ahblite_busmatrix_outputstage_dtcm

Overview:
AHB-Lite bus-matrix output stage for the DTCM slave port. It is the slave-side counterpart of the per-master decoders: it accepts HSEL_Decoder_*_DTCM plus address/control from the DMA and SYS masters, and arbitrates address-phase ownership. It drives the single DTCM AHB-Lite slave bus and returns ACTIVE_Outputstage_DTCM per master plus shared HREADYOUT/HRESP/HRDATA. Write data and the data-phase owner are tracked across wait states.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
HCLK  input  1  bus clock
HRESET  input  1  asynchronous reset, active-high
HSEL_Decoder_DMA_DTCM  input  1  DMA decoder selects DTCM
HSEL_Decoder_SYS_DTCM  input  1  SYS decoder selects DTCM
HADDR_DMA / HADDR_SYS  input  ADDR_W  master address
HTRANS_DMA / HTRANS_SYS  input  2  master transfer type
HWRITE_DMA / HWRITE_SYS  input  1  write
HSIZE_DMA / HSIZE_SYS  input  3  size
HBURST_DMA / HBURST_SYS  input  3  burst
HPROT_DMA / HPROT_SYS  input  4  protection
HMASTLOCK_DMA / HMASTLOCK_SYS  input  1  locked transfer
HWDATA_DMA / HWDATA_SYS  input  DATA_W  write data
ACTIVE_Outputstage_DMA  output  1  DMA owns address phase
ACTIVE_Outputstage_SYS  output  1  SYS owns address phase
HSEL_DTCM  output  1  slave select
HADDR_DTCM  output  ADDR_W  muxed address
HTRANS_DTCM  output  2  muxed HTRANS, forced IDLE when owner not requesting
HWRITE_DTCM / HSIZE_DTCM / HBURST_DTCM / HPROT_DTCM / HMASTLOCK_DTCM  output  1/3/3/4/1  muxed control
HWDATA_DTCM  output  DATA_W  write data muxed by data-phase owner
HREADY_DTCM  output  1  equals HREADYOUT_DTCM
HREADYOUT_DTCM  input  1  slave ready
HRESP_DTCM  input  2  slave response
HRDATA_DTCM  input  DATA_W  slave read data
HREADYOUT_Outputstage_DTCM  output  1  equals HREADYOUT_DTCM
HRESP_Outputstage_DTCM  output  2  equals HRESP_DTCM
HRDATA_Outputstage_DTCM  output  DATA_W  equals HRDATA_DTCM

Behaviour:
- req_m = HSEL_Decoder_m_DTCM & HTRANS_m[1].
- State registers: last_owner (0=SYS, 1=DMA), data_owner, data_valid. Reset: last_owner=SYS, data_owner=SYS, data_valid=0.
- Combinational address owner sel:
  - hold if last_owner presents HMASTLOCK=1 or HTRANS=SEQ/BUSY with its HSEL high;
  - else round-robin: the requester other than last_owner wins if requesting, else last_owner if requesting;
  - else park on last_owner.
- ACTIVE_Outputstage_m = (sel==m). Exactly one ACTIVE is high at all times, including reset.
- Slave outputs mux address/control from sel. HSEL_DTCM = HSEL_Decoder_sel_DTCM. HTRANS_DTCM = IDLE when !req_sel and owner is not BUSY.
- On HCLK rise with HREADYOUT_DTCM=1: last_owner<=sel; data_owner<=sel; data_valid<=req_sel.
- With HREADYOUT_DTCM=0: all state holds, so the address phase and owner stay stable during wait states. The arbitration inputs of a non-owner are ignored.
- HWDATA_DTCM = data_valid ? HWDATA_data_owner : 0. Zero latency on the mux.
- Error response (HRESP=1, two cycles): no special handling; pass-through, and state updates only on the HREADY-high cycle.
- Reset mid-transfer: state returns to reset values immediately, asynchronously. HTRANS_DTCM then follows SYS combinationally.

Optional Feature:
DTCM_FIXED_PRIO_EN. When defined, arbitration is fixed-priority: DMA wins over SYS whenever both request and no hold applies; last_owner still tracks hold. When undefined, arbitration is round-robin as above.

Decomposition:
- Shared package (bus-matrix common include): HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), HRESP OKAY/ERROR, owner IDs OWNER_SYS=0 and OWNER_DMA=1.
- One natural sub-module: ahblite_busmatrix_arbiter_2m. It takes req_m, hold, last_owner and returns sel, and contains the DTCM_FIXED_PRIO_EN switch.

Test Plan:
- Reset: HRESET=1 with both masters NONSEQ. Required: ACTIVE_SYS=1, ACTIVE_DMA=0, data_valid=0, HWDATA_DTCM=0.
- Contention (both NONSEQ single, HREADYOUT=1):
  - round-robin build: grants alternate DMA, SYS, DMA on consecutive cycles;
  - with DTCM_FIXED_PRIO_EN: DMA on every cycle.
- Wait state: SYS write to 0x2000_0010, HREADYOUT=0 for 3 cycles. Required: HADDR_DTCM held at 0x2000_0010 and HWDATA_DTCM = HWDATA_SYS (0xA5A5_5A5A) for all 3 cycles, ACTIVE stable.
- Burst hold: DMA INCR4 (NONSEQ then 3 SEQ) with SYS requesting throughout. Required: DMA keeps ACTIVE for all 4 beats; SYS is granted on the 5th cycle.
- Lock: SYS HMASTLOCK=1 for 3 transfers while DMA requests. Required: DMA is not granted until SYS drops the lock.
- Error pass-through: slave HRESP=ERROR with HREADYOUT 0 then 1. Required: HRESP_Outputstage_DTCM=ERROR both cycles; owner changes only after the second cycle.

Source files
------------

// File: rtl/ahblite_busmatrix_outputstage_dtcm_pkg.sv
// Shared bus-matrix definitions: AHB-Lite HTRANS/HRESP encodings and DTCM
// master owner IDs, plus small helpers used by the output stage and arbiter.
package ahblite_busmatrix_outputstage_dtcm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic {
    OWNER_SYS = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t owner);
    return (owner == OWNER_DMA) ? OWNER_SYS : OWNER_DMA;
  endfunction

  // SEQ and BUSY both mean the owner is mid-burst and must keep the bus.
  function automatic logic is_burst_cont(input logic [1:0] trans);
    return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahblite_busmatrix_arbiter_2m.sv
// Two-master address-phase arbiter. Round-robin by default; defining
// DTCM_FIXED_PRIO_EN switches to fixed priority with DMA above SYS.
module ahblite_busmatrix_arbiter_2m
  import ahblite_busmatrix_outputstage_dtcm_pkg::*;
(
  input  logic   i_req_sys,
  input  logic   i_req_dma,
  input  logic   i_hold,
  input  owner_t i_last_owner,
  output owner_t o_sel
);

  logic w_req_other;

  // Owner selection: hold beats everything, otherwise grant and finally park on last owner.
  always_comb begin
    o_sel       = i_last_owner;
    w_req_other = (i_last_owner == OWNER_DMA) ? i_req_sys : i_req_dma;
    if (i_hold) begin
      o_sel = i_last_owner;
    end else begin
`ifdef DTCM_FIXED_PRIO_EN
      if (i_req_dma) begin
        o_sel = OWNER_DMA;
      end else if (i_req_sys) begin
        o_sel = OWNER_SYS;
      end else begin
        o_sel = i_last_owner;
      end
`else
      if (w_req_other) begin
        o_sel = other_owner(i_last_owner);
      end else begin
        o_sel = i_last_owner;
      end
`endif
    end
  end

endmodule

// File: rtl/ahblite_busmatrix_outputstage_dtcm.sv
// DTCM slave-port output stage: arbitrates DMA/SYS address phases, muxes
// control onto the DTCM bus and steers write data by data-phase owner.
module ahblite_busmatrix_outputstage_dtcm
  import ahblite_busmatrix_outputstage_dtcm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL_Decoder_DMA_DTCM,
  input  logic              HSEL_Decoder_SYS_DTCM,
  input  logic [ADDR_W-1:0] HADDR_DMA,
  input  logic [ADDR_W-1:0] HADDR_SYS,
  input  logic [1:0]        HTRANS_DMA,
  input  logic [1:0]        HTRANS_SYS,
  input  logic              HWRITE_DMA,
  input  logic              HWRITE_SYS,
  input  logic [2:0]        HSIZE_DMA,
  input  logic [2:0]        HSIZE_SYS,
  input  logic [2:0]        HBURST_DMA,
  input  logic [2:0]        HBURST_SYS,
  input  logic [3:0]        HPROT_DMA,
  input  logic [3:0]        HPROT_SYS,
  input  logic              HMASTLOCK_DMA,
  input  logic              HMASTLOCK_SYS,
  input  logic [DATA_W-1:0] HWDATA_DMA,
  input  logic [DATA_W-1:0] HWDATA_SYS,
  output logic              ACTIVE_Outputstage_DMA,
  output logic              ACTIVE_Outputstage_SYS,
  output logic              HSEL_DTCM,
  output logic [ADDR_W-1:0] HADDR_DTCM,
  output logic [1:0]        HTRANS_DTCM,
  output logic              HWRITE_DTCM,
  output logic [2:0]        HSIZE_DTCM,
  output logic [2:0]        HBURST_DTCM,
  output logic [3:0]        HPROT_DTCM,
  output logic              HMASTLOCK_DTCM,
  output logic [DATA_W-1:0] HWDATA_DTCM,
  output logic              HREADY_DTCM,
  input  logic              HREADYOUT_DTCM,
  input  logic [1:0]        HRESP_DTCM,
  input  logic [DATA_W-1:0] HRDATA_DTCM,
  output logic              HREADYOUT_Outputstage_DTCM,
  output logic [1:0]        HRESP_Outputstage_DTCM,
  output logic [DATA_W-1:0] HRDATA_Outputstage_DTCM
);

  owner_t r_last_owner;
  owner_t r_data_owner;
  logic   r_data_valid;

  logic   w_req_sys;
  logic   w_req_dma;
  logic   w_req_sel;
  logic   w_hold;
  owner_t w_arb_sel;
  owner_t w_sel;

  assign w_req_sys = HSEL_Decoder_SYS_DTCM & HTRANS_SYS[1];
  assign w_req_dma = HSEL_Decoder_DMA_DTCM & HTRANS_DMA[1];

  // Keep the bus with the last owner during locks, bursts and slave wait states.
  always_comb begin
    w_hold = 1'b0;
    if (!HREADYOUT_DTCM) begin
      w_hold = 1'b1;
    end else if (r_last_owner == OWNER_DMA) begin
      w_hold = HSEL_Decoder_DMA_DTCM & (HMASTLOCK_DMA | is_burst_cont(HTRANS_DMA));
    end else begin
      w_hold = HSEL_Decoder_SYS_DTCM & (HMASTLOCK_SYS | is_burst_cont(HTRANS_SYS));
    end
  end

  ahblite_busmatrix_arbiter_2m u_arbiter (
    .i_req_sys    (w_req_sys),
    .i_req_dma    (w_req_dma),
    .i_hold       (w_hold),
    .i_last_owner (r_last_owner),
    .o_sel        (w_arb_sel)
  );

  // Reset forces SYS ownership so exactly one ACTIVE stays high even while reset is asserted.
  assign w_sel = HRESET ? OWNER_SYS : w_arb_sel;

  assign ACTIVE_Outputstage_DMA = (w_sel == OWNER_DMA);
  assign ACTIVE_Outputstage_SYS = (w_sel == OWNER_SYS);

  // Address/control mux toward the slave; a non-requesting owner shows IDLE unless it is BUSY.
  always_comb begin
    if (w_sel == OWNER_DMA) begin
      w_req_sel      = w_req_dma;
      HSEL_DTCM      = HSEL_Decoder_DMA_DTCM;
      HADDR_DTCM     = HADDR_DMA;
      HTRANS_DTCM    = HTRANS_DMA;
      HWRITE_DTCM    = HWRITE_DMA;
      HSIZE_DTCM     = HSIZE_DMA;
      HBURST_DTCM    = HBURST_DMA;
      HPROT_DTCM     = HPROT_DMA;
      HMASTLOCK_DTCM = HMASTLOCK_DMA;
    end else begin
      w_req_sel      = w_req_sys;
      HSEL_DTCM      = HSEL_Decoder_SYS_DTCM;
      HADDR_DTCM     = HADDR_SYS;
      HTRANS_DTCM    = HTRANS_SYS;
      HWRITE_DTCM    = HWRITE_SYS;
      HSIZE_DTCM     = HSIZE_SYS;
      HBURST_DTCM    = HBURST_SYS;
      HPROT_DTCM     = HPROT_SYS;
      HMASTLOCK_DTCM = HMASTLOCK_SYS;
    end
    if (!w_req_sel && (HTRANS_DTCM != HTRANS_BUSY)) begin
      HTRANS_DTCM = HTRANS_IDLE;
    end else begin
      HTRANS_DTCM = HTRANS_DTCM;
    end
  end

  // Write data follows whoever owns the current data phase.
  always_comb begin
    if (!r_data_valid) begin
      HWDATA_DTCM = {DATA_W{1'b0}};
    end else if (r_data_owner == OWNER_DMA) begin
      HWDATA_DTCM = HWDATA_DMA;
    end else begin
      HWDATA_DTCM = HWDATA_SYS;
    end
  end

  assign HREADY_DTCM                = HREADYOUT_DTCM;
  assign HREADYOUT_Outputstage_DTCM = HREADYOUT_DTCM;
  assign HRESP_Outputstage_DTCM     = HRESP_DTCM;
  assign HRDATA_Outputstage_DTCM    = HRDATA_DTCM;

  // Ownership state advances only on completed (HREADY-high) cycles.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_last_owner <= OWNER_SYS;
      r_data_owner <= OWNER_SYS;
      r_data_valid <= 1'b0;
    end else if (HREADYOUT_DTCM) begin
      r_last_owner <= w_sel;
      r_data_owner <= w_sel;
      r_data_valid <= w_req_sel;
    end
  end

endmodule

// File: tb/tb_ahblite_busmatrix_outputstage_dtcm.sv
// Directed self-checking bench for the DTCM output stage; expectations track
// DTCM_FIXED_PRIO_EN when it is defined.
module tb_ahblite_busmatrix_outputstage_dtcm;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL_Decoder_DMA_DTCM, HSEL_Decoder_SYS_DTCM;
  logic [31:0] HADDR_DMA, HADDR_SYS;
  logic [1:0]  HTRANS_DMA, HTRANS_SYS;
  logic        HWRITE_DMA, HWRITE_SYS;
  logic [2:0]  HSIZE_DMA, HSIZE_SYS, HBURST_DMA, HBURST_SYS;
  logic [3:0]  HPROT_DMA, HPROT_SYS;
  logic        HMASTLOCK_DMA, HMASTLOCK_SYS;
  logic [31:0] HWDATA_DMA, HWDATA_SYS;
  logic        ACTIVE_Outputstage_DMA, ACTIVE_Outputstage_SYS;
  logic        HSEL_DTCM;
  logic [31:0] HADDR_DTCM;
  logic [1:0]  HTRANS_DTCM;
  logic        HWRITE_DTCM;
  logic [2:0]  HSIZE_DTCM, HBURST_DTCM;
  logic [3:0]  HPROT_DTCM;
  logic        HMASTLOCK_DTCM;
  logic [31:0] HWDATA_DTCM;
  logic        HREADY_DTCM;
  logic        HREADYOUT_DTCM;
  logic [1:0]  HRESP_DTCM;
  logic [31:0] HRDATA_DTCM;
  logic        HREADYOUT_Outputstage_DTCM;
  logic [1:0]  HRESP_Outputstage_DTCM;
  logic [31:0] HRDATA_Outputstage_DTCM;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahblite_busmatrix_outputstage_dtcm #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_Decoder_DMA_DTCM(HSEL_Decoder_DMA_DTCM), .HSEL_Decoder_SYS_DTCM(HSEL_Decoder_SYS_DTCM),
    .HADDR_DMA(HADDR_DMA), .HADDR_SYS(HADDR_SYS),
    .HTRANS_DMA(HTRANS_DMA), .HTRANS_SYS(HTRANS_SYS),
    .HWRITE_DMA(HWRITE_DMA), .HWRITE_SYS(HWRITE_SYS),
    .HSIZE_DMA(HSIZE_DMA), .HSIZE_SYS(HSIZE_SYS),
    .HBURST_DMA(HBURST_DMA), .HBURST_SYS(HBURST_SYS),
    .HPROT_DMA(HPROT_DMA), .HPROT_SYS(HPROT_SYS),
    .HMASTLOCK_DMA(HMASTLOCK_DMA), .HMASTLOCK_SYS(HMASTLOCK_SYS),
    .HWDATA_DMA(HWDATA_DMA), .HWDATA_SYS(HWDATA_SYS),
    .ACTIVE_Outputstage_DMA(ACTIVE_Outputstage_DMA), .ACTIVE_Outputstage_SYS(ACTIVE_Outputstage_SYS),
    .HSEL_DTCM(HSEL_DTCM), .HADDR_DTCM(HADDR_DTCM), .HTRANS_DTCM(HTRANS_DTCM),
    .HWRITE_DTCM(HWRITE_DTCM), .HSIZE_DTCM(HSIZE_DTCM), .HBURST_DTCM(HBURST_DTCM),
    .HPROT_DTCM(HPROT_DTCM), .HMASTLOCK_DTCM(HMASTLOCK_DTCM), .HWDATA_DTCM(HWDATA_DTCM),
    .HREADY_DTCM(HREADY_DTCM), .HREADYOUT_DTCM(HREADYOUT_DTCM),
    .HRESP_DTCM(HRESP_DTCM), .HRDATA_DTCM(HRDATA_DTCM),
    .HREADYOUT_Outputstage_DTCM(HREADYOUT_Outputstage_DTCM),
    .HRESP_Outputstage_DTCM(HRESP_Outputstage_DTCM),
    .HRDATA_Outputstage_DTCM(HRDATA_Outputstage_DTCM)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_masters();
    HSEL_Decoder_DMA_DTCM = 1'b0; HSEL_Decoder_SYS_DTCM = 1'b0;
    HTRANS_DMA = T_IDLE; HTRANS_SYS = T_IDLE;
    HMASTLOCK_DMA = 1'b0; HMASTLOCK_SYS = 1'b0;
    HREADYOUT_DTCM = 1'b1; HRESP_DTCM = 2'b00;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    idle_masters();
    HADDR_DMA = 32'h2000_0100; HADDR_SYS = 32'h2000_0200;
    HWRITE_DMA = 1'b1; HWRITE_SYS = 1'b1;
    HSIZE_DMA = 3'd2; HSIZE_SYS = 3'd2; HBURST_DMA = 3'd0; HBURST_SYS = 3'd0;
    HPROT_DMA = 4'h3; HPROT_SYS = 4'hA;
    HWDATA_DMA = 32'h1111_1111; HWDATA_SYS = 32'h2222_2222;
    HRDATA_DTCM = 32'h0;
    HSEL_Decoder_DMA_DTCM = 1'b1; HSEL_Decoder_SYS_DTCM = 1'b1;
    HTRANS_DMA = T_NONSEQ; HTRANS_SYS = T_NONSEQ;
    tick(); tick(); #1;
    checks++; if (ACTIVE_Outputstage_SYS !== 1'b1) begin errors++; $display("FAIL reset_active_sys got=%b exp=1", ACTIVE_Outputstage_SYS); end
    checks++; if (ACTIVE_Outputstage_DMA !== 1'b0) begin errors++; $display("FAIL reset_active_dma got=%b exp=0", ACTIVE_Outputstage_DMA); end
    checks++; if (HWDATA_DTCM !== 32'h0) begin errors++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA_DTCM); end
    checks++; if (HADDR_DTCM !== 32'h2000_0200 || HPROT_DTCM !== 4'hA) begin errors++; $display("FAIL reset_sys_mux got=%h/%h exp=20000200/a", HADDR_DTCM, HPROT_DTCM); end
    HRESET = 1'b0;
  endtask

  task automatic test_contention();
    logic [2:0]  exp_dma;
    logic [31:0] exp_wd [3];
`ifdef DTCM_FIXED_PRIO_EN
    exp_dma = 3'b111;
    exp_wd[0] = 32'h0; exp_wd[1] = 32'h1111_1111; exp_wd[2] = 32'h1111_1111;
`else
    exp_dma = 3'b101;
    exp_wd[0] = 32'h0; exp_wd[1] = 32'h1111_1111; exp_wd[2] = 32'h2222_2222;
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ACTIVE_Outputstage_DMA !== exp_dma[i] || ACTIVE_Outputstage_SYS !== ~exp_dma[i]) begin
        errors++; $display("FAIL contention_grant cyc=%0d got dma=%b sys=%b exp dma=%b", i, ACTIVE_Outputstage_DMA, ACTIVE_Outputstage_SYS, exp_dma[i]);
      end
      checks++; if (HWDATA_DTCM !== exp_wd[i]) begin errors++; $display("FAIL contention_hwdata cyc=%0d got=%h exp=%h", i, HWDATA_DTCM, exp_wd[i]); end
      tick();
    end
    idle_masters();
    tick();
  endtask

  task automatic test_wait_state();
    HSEL_Decoder_SYS_DTCM = 1'b1; HTRANS_SYS = T_NONSEQ; HWRITE_SYS = 1'b1;
    HADDR_SYS = 32'h2000_0010; HWDATA_SYS = 32'h0;
    #1;
    checks++; if (ACTIVE_Outputstage_SYS !== 1'b1 || HADDR_DTCM !== 32'h2000_0010) begin errors++; $display("FAIL wait_addr_phase got sys=%b addr=%h exp 1/20000010", ACTIVE_Outputstage_SYS, HADDR_DTCM); end
    tick();
    HWDATA_SYS = 32'hA5A5_5A5A; HREADYOUT_DTCM = 1'b0;
    HSEL_Decoder_DMA_DTCM = 1'b1; HTRANS_DMA = T_NONSEQ; HADDR_DMA = 32'h2000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (HADDR_DTCM !== 32'h2000_0010 || HWDATA_DTCM !== 32'hA5A5_5A5A) begin errors++; $display("FAIL wait_hold cyc=%0d got addr=%h wdata=%h exp 20000010/a5a55a5a", i, HADDR_DTCM, HWDATA_DTCM); end
      checks++; if (ACTIVE_Outputstage_SYS !== 1'b1 || ACTIVE_Outputstage_DMA !== 1'b0 || HREADY_DTCM !== 1'b0) begin errors++; $display("FAIL wait_owner cyc=%0d got sys=%b dma=%b rdy=%b exp 1/0/0", i, ACTIVE_Outputstage_SYS, ACTIVE_Outputstage_DMA, HREADY_DTCM); end
      tick();
    end
    HREADYOUT_DTCM = 1'b1; HSEL_Decoder_SYS_DTCM = 1'b0; HTRANS_SYS = T_IDLE;
    #1;
    checks++; if (ACTIVE_Outputstage_DMA !== 1'b1 || HWDATA_DTCM !== 32'hA5A5_5A5A) begin errors++; $display("FAIL wait_release got dma=%b wdata=%h exp 1/a5a55a5a", ACTIVE_Outputstage_DMA, HWDATA_DTCM); end
    tick();
    idle_masters();
    tick();
  endtask

  task automatic test_burst_hold();
    logic [1:0] beats [4];
    beats[0] = T_NONSEQ; beats[1] = T_SEQ; beats[2] = T_SEQ; beats[3] = T_SEQ;
    HSEL_Decoder_SYS_DTCM = 1'b1; HTRANS_SYS = T_NONSEQ;
    tick();
    HSEL_Decoder_DMA_DTCM = 1'b1; HBURST_DMA = 3'd3;
    for (int i = 0; i < 4; i++) begin
      HTRANS_DMA = beats[i]; HADDR_DMA = 32'h2000_0400 + 32'(i * 4);
      #1;
      checks++; if (ACTIVE_Outputstage_DMA !== 1'b1 || HTRANS_DTCM !== beats[i] || HADDR_DTCM !== 32'h2000_0400 + 32'(i * 4)) begin
        errors++; $display("FAIL burst_beat%0d got dma=%b trans=%b addr=%h exp 1/%b/%h", i, ACTIVE_Outputstage_DMA, HTRANS_DTCM, HADDR_DTCM, beats[i], 32'h2000_0400 + 32'(i * 4));
      end
      tick();
    end
    HTRANS_DMA = T_IDLE;
    #1;
    checks++; if (ACTIVE_Outputstage_SYS !== 1'b1 || HTRANS_DTCM !== T_NONSEQ) begin errors++; $display("FAIL burst_handover got sys=%b trans=%b exp 1/10", ACTIVE_Outputstage_SYS, HTRANS_DTCM); end
    tick();
    idle_masters();
  endtask

  task automatic test_lock();
    HSEL_Decoder_SYS_DTCM = 1'b1; HTRANS_SYS = T_NONSEQ; HMASTLOCK_SYS = 1'b1;
    HSEL_Decoder_DMA_DTCM = 1'b1; HTRANS_DMA = T_NONSEQ;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ACTIVE_Outputstage_SYS !== 1'b1 || HMASTLOCK_DTCM !== 1'b1) begin errors++; $display("FAIL lock_hold cyc=%0d got sys=%b lock=%b exp 1/1", i, ACTIVE_Outputstage_SYS, HMASTLOCK_DTCM); end
      tick();
    end
    HMASTLOCK_SYS = 1'b0; HTRANS_SYS = T_IDLE;
    #1;
    checks++; if (ACTIVE_Outputstage_DMA !== 1'b1 || HMASTLOCK_DTCM !== 1'b0) begin errors++; $display("FAIL lock_release got dma=%b lock=%b exp 1/0", ACTIVE_Outputstage_DMA, HMASTLOCK_DTCM); end
    tick();
    idle_masters();
    tick();
  endtask

  task automatic test_error();
    HSEL_Decoder_SYS_DTCM = 1'b1; HTRANS_SYS = T_NONSEQ; HWRITE_SYS = 1'b0;
    tick();
    HSEL_Decoder_SYS_DTCM = 1'b0; HTRANS_SYS = T_IDLE;
    HSEL_Decoder_DMA_DTCM = 1'b1; HTRANS_DMA = T_NONSEQ;
    HREADYOUT_DTCM = 1'b0; HRESP_DTCM = 2'b01; HRDATA_DTCM = 32'hDEAD_BEEF;
    #1;
    checks++; if (HRESP_Outputstage_DTCM !== 2'b01 || HREADYOUT_Outputstage_DTCM !== 1'b0) begin errors++; $display("FAIL err_cycle1_resp got=%b/%b exp 01/0", HRESP_Outputstage_DTCM, HREADYOUT_Outputstage_DTCM); end
    checks++; if (ACTIVE_Outputstage_SYS !== 1'b1) begin errors++; $display("FAIL err_cycle1_owner got sys=%b exp 1", ACTIVE_Outputstage_SYS); end
    tick();
    HREADYOUT_DTCM = 1'b1;
    #1;
    checks++; if (HRESP_Outputstage_DTCM !== 2'b01 || HRDATA_Outputstage_DTCM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_cycle2_resp got=%b/%h exp 01/deadbeef", HRESP_Outputstage_DTCM, HRDATA_Outputstage_DTCM); end
    tick();
    idle_masters();
    #1;
    checks++; if (ACTIVE_Outputstage_DMA !== 1'b1) begin errors++; $display("FAIL err_owner_after got dma=%b exp 1", ACTIVE_Outputstage_DMA); end
    tick();
  endtask

  task automatic test_reset_midtransfer();
    HSEL_Decoder_DMA_DTCM = 1'b1; HTRANS_DMA = T_NONSEQ; HWRITE_DMA = 1'b1; HWDATA_DMA = 32'h3C3C_C3C3;
    tick();
    HTRANS_DMA = T_SEQ; HSEL_Decoder_SYS_DTCM = 1'b1; HTRANS_SYS = T_NONSEQ;
    #1;
    checks++; if (ACTIVE_Outputstage_DMA !== 1'b1 || HWDATA_DTCM !== 32'h3C3C_C3C3) begin errors++; $display("FAIL midrst_before got dma=%b wdata=%h exp 1/3c3cc3c3", ACTIVE_Outputstage_DMA, HWDATA_DTCM); end
    HRESET = 1'b1;
    #1;
    checks++; if (ACTIVE_Outputstage_SYS !== 1'b1 || HWDATA_DTCM !== 32'h0 || HTRANS_DTCM !== T_NONSEQ) begin errors++; $display("FAIL midrst_after got sys=%b wdata=%h trans=%b exp 1/0/10", ACTIVE_Outputstage_SYS, HWDATA_DTCM, HTRANS_DTCM); end
    tick();
    HRESET = 1'b0;
    idle_masters();
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_wait_state();
    test_burst_hold();
    test_lock();
    test_error();
    test_reset_midtransfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
